// File: rtl/booth_seq_multiplier_if.sv
// Handshake bundle between the MAC front end, the Booth multiplier and the
// accumulator stage.
//   in_valid / in_ready : operand handshake (front end -> multiplier)
//   in_a / in_b         : multiplicand / multiplier, two's complement
//   out_valid/out_ready : product handshake (multiplier -> accumulator)
//   out_p               : signed 2*WIDTH-bit product
//   busy                : multiplier is in RUN or DONE
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_p;
    logic                   busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential signed WIDTH x WIDTH radix-4 Booth multiplier. One Booth digit
// is retired per clock through a single row of WIDTH+1 encoder/decoder cells.
// The shifted partial products are accumulated into a 2*WIDTH-bit product.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : booth_seq_multiplier_if.slave (operand/product handshakes, busy)
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for an operand pair, in_ready high
// S_RUN  | retiring Booth digit r_cnt, one per clock, N = WIDTH/2 digits
// S_DONE | product held on out_p with out_valid high until out_ready
module booth_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    booth_seq_multiplier_if.slave   bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [CW-1:0]          r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;

    logic [CW:0]            w_sh;
    logic [WIDTH:0]         w_b_ext;
    logic [WIDTH:0]         w_b_sh;
    logic                   w_bip1;
    logic                   w_bi;
    logic                   w_bim1;
    logic                   w_neg;
    logic                   w_one;
    logic                   w_two;
    logic [WIDTH+1:0]       w_a_ext;
    logic [WIDTH:0]         w_pp;
    logic [2*WIDTH-1:0]     w_pp_sext;
    logic [2*WIDTH-1:0]     w_term;

    // Digit i sits at weight 4^i, i.e. a shift of 2*i.
    assign w_sh    = {r_cnt, 1'b0};

    // B[-1] = 0 is the appended LSB; the digit window is bits 2i+1..2i-1.
    assign w_b_ext = {r_b, 1'b0};
    assign w_b_sh  = w_b_ext >> w_sh;
    assign w_bip1  = w_b_sh[2];
    assign w_bi    = w_b_sh[1];
    assign w_bim1  = w_b_sh[0];

    // Digit 111 is -0: no select and no negation, so the row is all zero.
    assign w_neg   = w_bip1 & ~(w_bi & w_bim1);
    assign w_one   = w_bi ^ w_bim1;
    assign w_two   = (w_bip1 & ~w_bi & ~w_bim1) | (~w_bip1 & w_bi & w_bim1);

    // Index k+1 holds A[k]; index 0 is A[-1] = 0, top index repeats the sign.
    assign w_a_ext = {r_a[WIDTH-1], r_a, 1'b0};

    always_comb begin
        w_pp = '0;
        for (int j = 0; j <= WIDTH; j++) begin
            w_pp[j] = ((w_one & w_a_ext[j+1]) | (w_two & w_a_ext[j])) ^ w_neg;
        end
    end

    // The row is a one's complement for negative digits; the +1 correction is
    // folded in at the same weight so that -2*(-2^(WIDTH-1)) stays exact.
    assign w_pp_sext = {{(WIDTH-1){w_pp[WIDTH]}}, w_pp};
    assign w_term    = (w_pp_sext + {{(2*WIDTH-1){1'b0}}, w_neg}) << w_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_in_ready && bus.in_valid) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + w_term;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_acc;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier (WIDTH = 16). Stimulus pushes the
// expected product into a queue; a monitor pops and compares on every product
// handshake.
module tb_booth_seq_multiplier;
    localparam int W = 16;

    logic clk;
    logic rst;
    logic rand_ready;
    int   total;
    int   bad;
    logic [2*W-1:0] exp_q[$];

    booth_seq_multiplier_if #(.WIDTH(W)) ifc ();

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_product: got 0x%0h expected none", ifc.out_p);
            end else begin
                chk("product", 64'(ifc.out_p), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) ifc.out_ready = 1'($urandom_range(0, 1));
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] e, input bit push);
        int n = 0;
        while (!ifc.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 64'(ifc.in_ready), 64'd1);
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.in_a     = 16'hDEAD;
        ifc.in_b     = 16'hBEEF;
    endtask

    task automatic latency_check(input string name);
        int n = 0;
        while (!ifc.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(n), 64'd8);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic signed [W-1:0]   ra;
        logic signed [W-1:0]   rb;
        logic signed [2*W-1:0] rp;
        logic [2*W-1:0]        hold_p;
        bit                    seen;

        total = 0;
        bad   = 0;
        rand_ready    = 1'b0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.out_ready = 1'b0;

        vecs.push_back('{16'h8000, 16'h8000, 32'h40000000});
        vecs.push_back('{16'h7FFF, 16'h8000, 32'hC0008000});
        vecs.push_back('{16'hFFFF, 16'h0001, 32'hFFFFFFFF});
        vecs.push_back('{16'h0001, 16'hFFFF, 32'hFFFFFFFF});
        vecs.push_back('{16'h0000, 16'hFFFF, 32'h00000000});
        vecs.push_back('{16'hFFF9, 16'h0006, 32'hFFFFFFD6});
        vecs.push_back('{16'd1234, 16'hFFFE, 32'hFFFFF65C});
        vecs.push_back('{16'h7FFF, 16'h7FFF, 32'h3FFF0001});
        vecs.push_back('{16'h8000, 16'h7FFF, 32'hC0008000});
        vecs.push_back('{16'd21845, 16'd3, 32'h0000FFFF});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out_p", 64'(ifc.out_p), 64'd0);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(ifc.in_ready), 64'd1);

        // 3 x 5 with latency measurement
        ifc.out_ready = 1'b1;
        send(16'd3, 16'd5, 32'h0000000F, 1'b1);
        chk("busy_in_run", 64'(ifc.busy), 64'd1);
        chk("in_ready_in_run", 64'(ifc.in_ready), 64'd0);
        latency_check("latency_3x5");
        drain();

        foreach (vecs[k]) send(vecs[k].a, vecs[k].b, vecs[k].p, 1'b1);
        drain();

        // Backpressure: hold out_ready low for 5 cycles with out_valid up
        ifc.out_ready = 1'b0;
        send(16'd100, 16'hFFFD, 32'hFFFFFED4, 1'b1);
        latency_check("latency_bp");
        hold_p = ifc.out_p;
        chk("bp_value", 64'(hold_p), 64'h00000000FFFFFED4);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_p_stable", 64'(ifc.out_p), 64'(hold_p));
            chk("bp_in_ready_low", 64'(ifc.in_ready), 64'd0);
            chk("bp_out_valid_held", 64'(ifc.out_valid), 64'd1);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_handshake", 64'(ifc.in_ready), 64'd1);
        chk("out_valid_after_handshake", 64'(ifc.out_valid), 64'd0);
        send(16'hFFFB, 16'hFFFB, 32'h00000019, 1'b1);
        drain();

        // Reset during RUN cycle 4, with in_valid asserted alongside reset
        send(16'd7, 16'd9, 32'd63, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst          = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_a     = 16'd5;
        ifc.in_b     = 16'd5;
        @(posedge clk); #1;
        chk("midrun_rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("midrun_rst_busy", 64'(ifc.busy), 64'd0);
        chk("midrun_rst_out_p", 64'(ifc.out_p), 64'd0);
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ifc.out_valid) seen = 1'b1;
        end
        chk("no_product_after_rst", 64'(seen), 64'd0);
        send(16'hFED4, 16'd200, 32'hFFFF15A0, 1'b1);
        latency_check("latency_after_rst");
        drain();

        // Randomised pairs against a reference multiply, random gaps on both sides
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rp = ra * rb;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(ra, rb, rp, 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
